// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the sequential ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } opcode_e;

   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     sum;

   // Upper half accumulates the multiplicand; the lower half holds the remaining multiplier bits.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
      acc_next = {sum, acc[WIDTH-1:1]};
   end

   // done marks the cycle whose edge performs the final iteration; product is valid then.
   assign busy    = (count != '0);
   assign done    = (count == CW'(1));
   assign product = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         mcand <= '0;
         acc   <= '0;
      end else if (start) begin
         count <= CW'(WIDTH);
         mcand <= a;
         acc   <= {{WIDTH{1'b0}}, b};
      end else if (busy) begin
         count <= count - CW'(1);
         acc   <= acc_next;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and a multi-cycle unsigned multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           opcode,
   input  logic [WIDTH-1:0]     op1,
   input  logic [WIDTH-1:0]     op2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [3:0]           flags
);

   localparam int unsigned SW = $clog2(WIDTH);

   state_e             state;
   opcode_e            op;
   logic               accept;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [3:0]         mul_flags;
   logic [WIDTH-1:0]   alu_res;
   logic [3:0]         alu_flags;
   logic [WIDTH:0]     wide;
   logic [SW-1:0]      amt;

   assign op        = opcode_e'(opcode);
   assign amt       = op2[SW-1:0];
   assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (op1),
      .b       (op2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Shifts run one bit wider so the last bit shifted out lands in the extra position.
   always_comb begin
      alu_res   = '0;
      alu_flags = '0;
      wide      = '0;
      case (op)
         OP_ADD: begin
            wide             = {1'b0, op1} + {1'b0, op2};
            alu_res          = wide[WIDTH-1:0];
            alu_flags[FLG_C] = wide[WIDTH];
            alu_flags[FLG_V] = (op1[WIDTH-1] == op2[WIDTH-1]) && (wide[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB: begin
            wide             = {1'b0, op1} - {1'b0, op2};
            alu_res          = wide[WIDTH-1:0];
            alu_flags[FLG_C] = wide[WIDTH];
            alu_flags[FLG_V] = (op1[WIDTH-1] != op2[WIDTH-1]) && (wide[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_AND: alu_res = op1 & op2;
         OP_OR:  alu_res = op1 | op2;
         OP_XOR: alu_res = op1 ^ op2;
         OP_SHL: begin
            wide             = {1'b0, op1} << amt;
            alu_res          = wide[WIDTH-1:0];
            alu_flags[FLG_C] = wide[WIDTH];
         end
         OP_SHR: begin
            wide             = {op1, 1'b0} >> amt;
            alu_res          = wide[WIDTH:1];
            alu_flags[FLG_C] = wide[0];
         end
         default: ;
      endcase
      alu_flags[FLG_Z] = (alu_res == '0);
      alu_flags[FLG_N] = alu_res[WIDTH-1];
   end

   always_comb begin
      mul_flags        = '0;
      mul_flags[FLG_N] = mul_product[2*WIDTH-1];
      mul_flags[FLG_Z] = (mul_product == '0);
      mul_flags[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         // Accept is only possible in IDLE or in HOLD with out_ready, so it is handled once here.
         if (accept) begin
            if (op == OP_MUL) begin
               state <= ST_MUL;
            end else begin
               state     <= ST_HOLD;
               out_valid <= 1'b1;
               result    <= {{WIDTH{1'b0}}, alu_res};
               flags     <= alu_flags;
            end
         end else begin
            case (state)
               ST_IDLE: ;
               ST_MUL: begin
                  if (mul_done) begin
                     state     <= ST_HOLD;
                     out_valid <= 1'b1;
                     result    <= mul_product;
                     flags     <= mul_flags;
                  end else if (!mul_busy) begin
                     state <= ST_IDLE;
                  end
               end
               ST_HOLD: if (out_ready) state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus multiply, back-pressure and reset sequences.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [7:0]  op1;
   logic [7:0]  op2;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs[13];

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one operation at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      opcode   = o;
      op1      = a;
      op2      = b;
      cycle();
      in_valid = 1'b0;
      op1      = 8'h5A;
      op2      = 8'hC3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned seen;

      // flags are {N,Z,C,V}
      vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0000, 4'b0110};
      vecs[1]  = '{OP_SUB, 8'h80, 8'h01, 16'h007F, 4'b0001};
      vecs[2]  = '{OP_SUB, 8'h01, 8'h02, 16'h00FF, 4'b1010};
      vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 16'h0030, 4'b0000};
      vecs[4]  = '{OP_OR,  8'h00, 8'h00, 16'h0000, 4'b0100};
      vecs[5]  = '{OP_XOR, 8'hAA, 8'h55, 16'h00FF, 4'b1000};
      vecs[6]  = '{OP_SHL, 8'h81, 8'h01, 16'h0002, 4'b0010};
      vecs[7]  = '{OP_SHR, 8'h81, 8'h00, 16'h0081, 4'b1000};
      vecs[8]  = '{OP_SHR, 8'h81, 8'h07, 16'h0001, 4'b0000};
      vecs[9]  = '{OP_ADD, 8'h7F, 8'h01, 16'h0080, 4'b1001};
      vecs[10] = '{OP_SHL, 8'h81, 8'h08, 16'h0081, 4'b1000};
      vecs[11] = '{OP_SUB, 8'h05, 8'h05, 16'h0000, 4'b0100};
      vecs[12] = '{OP_SHR, 8'h40, 8'h07, 16'h0000, 4'b0110};

      rst       = 1'b1;
      in_valid  = 1'b0;
      opcode    = 3'b000;
      op1       = 8'h00;
      op2       = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset result", 32'(result), 32'h0);
      check("reset flags", 32'(flags), 32'h0);
      rst = 1'b0;
      cycle();
      check("post-reset in_ready", 32'(in_ready), 32'h1);

      // Back-to-back issue with out_ready held high: one result per cycle.
      for (int i = 0; i < 13; i++) begin
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'h1);
         in_valid = 1'b1;
         opcode   = vecs[i].op;
         op1      = vecs[i].a;
         op2      = vecs[i].b;
         cycle();
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'h1);
         check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
         check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].flg));
      end
      in_valid = 1'b0;
      cycle();
      check("table drain out_valid", 32'(out_valid), 32'h0);

      // MUL 0x0F*0x0F with the consumer stalled.
      out_ready = 1'b0;
      issue(OP_MUL, 8'h0F, 8'h0F);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("mul1 busy%0d out_valid", k), 32'(out_valid), 32'h0);
         check($sformatf("mul1 busy%0d in_ready", k), 32'(in_ready), 32'h0);
         cycle();
      end
      check("mul1 out_valid", 32'(out_valid), 32'h1);
      check("mul1 result", 32'(result), 32'h00E1);
      check("mul1 flags", 32'(flags), 32'h0);
      repeat (2) cycle();
      check("mul1 stall out_valid", 32'(out_valid), 32'h1);
      check("mul1 stall result", 32'(result), 32'h00E1);
      check("mul1 stall in_ready", 32'(in_ready), 32'h0);
      out_ready = 1'b1;
      #1;
      check("mul1 hold pass-through in_ready", 32'(in_ready), 32'h1);
      cycle();
      check("mul1 consumed out_valid", 32'(out_valid), 32'h0);

      issue(OP_MUL, 8'hFF, 8'hFF);
      repeat (8) cycle();
      check("mul2 out_valid", 32'(out_valid), 32'h1);
      check("mul2 result", 32'(result), 32'hFE01);
      check("mul2 flags", 32'(flags), 32'b1010);
      cycle();
      check("mul2 consumed out_valid", 32'(out_valid), 32'h0);

      // Back-pressure, then simultaneous consume and accept.
      out_ready = 1'b0;
      issue(OP_ADD, 8'h03, 8'h04);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'h1);
         check($sformatf("bp%0d result", k), 32'(result), 32'h0007);
         check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'h0);
         cycle();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      opcode    = OP_XOR;
      op1       = 8'hF0;
      op2       = 8'hFF;
      #1;
      check("bp swap in_ready", 32'(in_ready), 32'h1);
      check("bp swap old result", 32'(result), 32'h0007);
      cycle();
      in_valid = 1'b0;
      check("bp xor out_valid", 32'(out_valid), 32'h1);
      check("bp xor result", 32'(result), 32'h000F);
      check("bp xor flags", 32'(flags), 32'h0);
      cycle();
      check("bp drain out_valid", 32'(out_valid), 32'h0);

      // Reset four cycles into a multiply discards it.
      issue(OP_MUL, 8'h12, 8'h34);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst-mul in_ready during reset", 32'(in_ready), 32'h0);
      cycle();
      rst  = 1'b0;
      seen = 0;
      #1;
      check("rst-mul in_ready after release", 32'(in_ready), 32'h1);
      for (int k = 0; k < 12; k++) begin
         if (out_valid) seen++;
         cycle();
      end
      check("rst-mul no out_valid", 32'(seen), 32'h0);
      check("rst-mul result cleared", 32'(result), 32'h0);
      issue(OP_ADD, 8'h02, 8'h03);
      check("post-rst add out_valid", 32'(out_valid), 32'h1);
      check("post-rst add result", 32'(result), 32'h0005);
      check("post-rst add flags", 32'(flags), 32'h0);
      cycle();
      check("post-rst add consumed", 32'(out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
